// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access encodings,
// FSM states and the request legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal when funct3 is known for the direction, the address is aligned to
  // the access size and it falls inside the 4*depth_words byte window.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [31:0] addr, input int unsigned depth_words);
    logic        ok;
    logic [33:0] lim;
    lim = 34'(depth_words) << 2;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !addr[0];
      F3_HU:   ok = !we && !addr[0];
      F3_W:    ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    if ({2'b00, addr} >= lim) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering shared by the store path (byte enables, replicated data)
// and the load path (lane extract with sign/zero extension).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h0;
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_rdata = 32'h0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      F3_W:    o_rdata = i_rword;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: one request at a time, fixed latency,
// registered response held until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  logic [31:0] r_mem [DEPTH_WORDS];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic          w_accept;
  logic          w_go_resp;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [2:0]    w_acc_f3;
  logic [31:0]   w_acc_wdata;
  logic          w_legal;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_sh;
  logic [31:0]   w_ld_data;
  logic          w_mem_we;

  assign w_accept  = (r_state == IDLE) && req_valid && r_req_ready;
  assign w_go_resp = (LATENCY == 1) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));

  // With single-cycle latency the access happens on the accepting edge, so it
  // must see the live request rather than the captured copy.
  assign w_acc_we    = (r_state == IDLE) ? req_we     : r_we;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_acc_f3    = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;

  assign w_legal  = is_legal(w_acc_we, w_acc_f3, w_acc_addr, DEPTH_WORDS);
  assign w_idx    = w_acc_addr[AW+1:2];
  assign w_mem_we = !reset && w_go_resp && w_acc_we && w_legal;

  dmem_lane_align u_lane_align (
    .i_addr_lo (w_acc_addr[1:0]),
    .i_funct3  (w_acc_f3),
    .i_wdata   (w_acc_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_funct3     <= 3'b000;
      r_wdata      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_funct3    <= req_funct3;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_cnt       <= CntInit;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_go_resp) begin
        r_state      <= RESP;
        r_req_ready  <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_err   <= !w_legal;
        r_resp_rdata <= (w_legal && !w_acc_we) ? w_ld_data : 32'h0;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores/loads, lane merge, errors,
// response back-pressure and reset abort, with hand-computed expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Issue one request, measure edges from acceptance to resp_valid, then take it.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    rd  = 32'hxxxx_xxxx;
    er  = 1'bx;
    lat = -1;
    req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) break;
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    if (resp_valid) begin
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b want 0 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL sw_0x10: got lat=%0d err=%b rdata=%h want 2 0 00000000", lat, er, rd);
    end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_0x10: got lat=%0d err=%b rdata=%h want 2 0 deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h11, 3'b000, 32'h000000AA, rd, er, lat);
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
      failures++;
      $display("FAIL sb_merge: got %h err=%b want deadaaef 0", rd, er);
    end
    do_req(1'b0, 32'h11, 3'b000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin
      failures++;
      $display("FAIL lb_0x11: got %h want ffffffaa", rd);
    end
    do_req(1'b0, 32'h11, 3'b100, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h000000AA) begin
      failures++;
      $display("FAIL lbu_0x11: got %h want 000000aa", rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 3'b010, 32'h11223344, rd, er, lat);
    do_req(1'b1, 32'h22, 3'b001, 32'h00008001, rd, er, lat);
    do_req(1'b0, 32'h22, 3'b001, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF8001) begin
      failures++;
      $display("FAIL lh_0x22: got %h want ffff8001", rd);
    end
    do_req(1'b0, 32'h22, 3'b101, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00008001) begin
      failures++;
      $display("FAIL lhu_0x22: got %h want 00008001", rd);
    end
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80013344) begin
      failures++;
      $display("FAIL sh_lanes_kept: got %h want 80013344", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        we_t [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad_t [6]  = '{32'h13, 32'h21, 32'h1000, 32'h10, 32'h10, 32'h20};
    logic [2:0]  f3_t [6]  = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011, 3'b100};
    for (int i = 0; i < 6; i++) begin
      do_req(we_t[i], ad_t[i], f3_t[i], 32'hFFFF_FFFF, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
        failures++;
        $display("FAIL err_case%0d: got err=%b rdata=%h lat=%0d want 1 00000000 2", i, er, rd, lat);
      end
    end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
      failures++;
      $display("FAIL err_readback_0x10: got %h err=%b want deadaaef 0", rd, er);
    end
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80013344 || er !== 1'b0) begin
      failures++;
      $display("FAIL err_readback_0x20: got %h err=%b want 80013344 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h20;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL bp_latency: got %0d want 2", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADAAEF || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got vld=%b rdata=%h err=%b rdy=%b want 1 deadaaef 0 0",
                 c, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h80013344) begin
      failures++;
      $display("FAIL bp_second_req: got vld=%b rdata=%h want 1 80013344", resp_valid, resp_rdata);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    logic        seen;
    do_req(1'b1, 32'h30, 3'b010, 32'hCAFEF00D, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = resp_valid;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready_in_reset: got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready_after: got %b want 1", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      seen = seen | resp_valid;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_resp: got resp_valid seen=%b want 0", seen);
    end
    do_req(1'b0, 32'h30, 3'b010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      failures++;
      $display("FAIL abort_store_dropped: got %h err=%b want cafef00d 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
